// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Responder side of the CPU instruction and data memory ports. Holds a 256x16
// instruction RAM and a 256x16 data RAM, answers CPU fetches/loads in the same
// cycle and commits CPU stores on the clock edge. A host load/dump port and a
// run-control FSM sit on top: the host loads a program, raises run_req, the
// block pulses cpu_start, watches for HALT or a cycle limit, then hands the
// RAMs back to the host so results can be read out.
//
// Ports:
//   clock, reset        system clock, asynchronous active-low reset
//   i_addr / i_rdata    CPU instruction fetch (combinational read)
//   d_addr / d_rdata    CPU data load (combinational read)
//   d_wdata / d_we      CPU data store, committed only while running
//   cpu_enable          CPU enable, high in START and RUN
//   cpu_start           one-cycle start pulse in START
//   host_valid/ready    host command handshake, accepted when both high
//   host_write/sel      1=write/0=read, 0=instruction RAM/1=data RAM
//   host_addr/wdata     host address and write data
//   host_rdata/rvalid   registered read data with one-cycle strobe
//   run_req             level request to run the loaded program
//   abort               stop request while running
//   busy / run_done     FSM not idle / FSM finished
//   timeout             sticky flag: last run hit the cycle limit or abort
//   cycle_count         RUN cycles of the current or last run
module cpu_mem_responder #(
  parameter logic [7:0]  HALT_OP    = 8'h08,
  parameter int          HALT_HOLD  = 4,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_rdata,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_wdata,
  input  logic        d_we,
  output logic [15:0] d_rdata,
  output logic        cpu_enable,
  output logic        cpu_start,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_write,
  input  logic        host_sel,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  input  logic        run_req,
  input  logic        abort,
  output logic        busy,
  output logic        run_done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  localparam logic [7:0] HOLD_COUNT = 8'(HALT_HOLD);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_imem [0:255];
  logic [15:0] r_dmem [0:255];
  logic [7:0]  r_prevAddr;
  logic [7:0]  r_haltCnt;
  logic [7:0]  w_haltNext;
  logic        w_accept;
  logic        w_hostRead;
  logic        w_halt;
  logic        w_limit;
  logic        r_cpuEnable;
  logic        r_cpuStart;
  logic        r_hostReady;
  logic [15:0] r_hostRdata;
  logic        r_hostRvalid;
  logic        r_busy;
  logic        r_runDone;
  logic        r_timeout;
  logic [15:0] r_cycleCount;

  // CPU read ports are plain asynchronous reads so the CPU sees data in the
  // same cycle it presents the address.
  assign i_rdata = r_imem[i_addr];
  assign d_rdata = r_dmem[d_addr];

  assign w_accept   = host_valid & r_hostReady;
  assign w_hostRead = w_accept & ~host_write;

  // A fetch only counts towards HALT when the CPU is parked on the HALT word,
  // i.e. the address has not moved since the previous cycle.
  assign w_haltNext = ((i_rdata[15:8] == HALT_OP) && (i_addr == r_prevAddr))
                      ? r_haltCnt + 8'd1 : 8'd0;
  assign w_halt     = (w_haltNext == HOLD_COUNT);
  assign w_limit    = (r_cycleCount == MAX_CYCLES - 16'd1);

  // Next-state logic. In IDLE a host command wins over run_req for that
  // cycle; in DONE the run_req level must drop before another run can begin.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:  if (run_req && !w_accept) w_nextState = START;
      START: w_nextState = RUN;
      RUN:   if (w_halt || w_limit || abort) w_nextState = DONE;
      DONE:  if (!run_req) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus all status outputs, registered from the next state so
  // they line up with the state they describe. host_ready comes out of reset
  // low and rises on the first clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_prevAddr   <= 8'd0;
      r_haltCnt    <= 8'd0;
      r_cpuEnable  <= 1'b0;
      r_cpuStart   <= 1'b0;
      r_hostReady  <= 1'b0;
      r_hostRdata  <= 16'd0;
      r_hostRvalid <= 1'b0;
      r_busy       <= 1'b0;
      r_runDone    <= 1'b0;
      r_timeout    <= 1'b0;
      r_cycleCount <= 16'd0;
    end else begin
      r_state      <= w_nextState;
      r_prevAddr   <= i_addr;
      r_cpuEnable  <= (w_nextState == START) || (w_nextState == RUN);
      r_cpuStart   <= (w_nextState == START);
      r_busy       <= (w_nextState != IDLE);
      r_runDone    <= (w_nextState == DONE);
      r_hostReady  <= (w_nextState == IDLE) || (w_nextState == DONE);
      r_hostRvalid <= w_hostRead;
      if (w_hostRead) begin
        r_hostRdata <= host_sel ? r_dmem[host_addr] : r_imem[host_addr];
      end
      if ((r_state == IDLE) && (w_nextState == START)) begin
        r_cycleCount <= 16'd0;
        r_timeout    <= 1'b0;
        r_haltCnt    <= 8'd0;
      end
      if (r_state == RUN) begin
        if (r_cycleCount != 16'hFFFF) begin
          r_cycleCount <= r_cycleCount + 16'd1;
        end
        r_haltCnt <= w_haltNext;
        // HALT beats the cycle limit, but an abort always flags timeout.
        if (abort || (w_limit && !w_halt)) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  // RAM writes. Contents survive reset; while reset is held the state is IDLE
  // and host_ready is low, so no write can slip through.
  always_ff @(posedge clock) begin
    if (w_accept && host_write) begin
      if (host_sel) begin
        r_dmem[host_addr] <= host_wdata;
      end else begin
        r_imem[host_addr] <= host_wdata;
      end
    end
    if ((r_state == RUN) && d_we) begin
      r_dmem[d_addr] <= d_wdata;
    end
  end

  assign cpu_enable  = r_cpuEnable;
  assign cpu_start   = r_cpuStart;
  assign host_ready  = r_hostReady;
  assign host_rdata  = r_hostRdata;
  assign host_rvalid = r_hostRvalid;
  assign busy        = r_busy;
  assign run_done    = r_runDone;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycleCount;

endmodule
